// File: rtl/instr_fetch_pkg.sv
// Shared core definitions: fetch FSM encoding, fetch buffer depth, control-transfer selects.
package instr_fetch_pkg;

  localparam int unsigned FETCH_FIFO_DEPTH = 2;

  // Control-transfer source selects used by the PC mux
  localparam logic [1:0] CTRL_TRANS_SEL_SEQ    = 2'd0;
  localparam logic [1:0] CTRL_TRANS_SEL_BRANCH = 2'd1;
  localparam logic [1:0] CTRL_TRANS_SEL_JUMP   = 2'd2;
  localparam logic [1:0] CTRL_TRANS_SEL_TRAP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer: registered storage, push/pop/flush, occupancy count.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_en;
  logic             pop_en;

  // Flush wins over any push/pop in the same cycle
  assign push_en = push_i && !flush_i;
  assign pop_en  = pop_i && !flush_i && (cnt_q != '0);

  // Pointer and count bookkeeping; pointers wrap modulo DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_en) wr_q <= wr_q + PTR_W'(1);
      if (pop_en)  rd_q <= rd_q + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; output is masked while empty so stale words never leak
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_q] <= data_i;
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

  // The fetch unit reserves space before requesting, so a full push is a bug
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_en && (cnt_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory request, buffered responses, flush handling.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH  = FETCH_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  pc_i,
  input  logic                   pc_valid_i,
  output logic                   pc_ready_o,
  input  logic                   flush_i,
  output logic                   instr_req_o,
  output logic [ADDR_WIDTH-1:0]  instr_addr_o,
  input  logic                   instr_gnt_i,
  input  logic                   instr_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] instr_rdata_i,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W   = CNT_W + 1;
  localparam int unsigned ENTRY_W = INSTR_WIDTH + ADDR_WIDTH;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  discard_q, discard_d;
  logic                  run_q;
  logic                  launch_c;
  logic                  outstanding_c;
  logic                  req_c;
  logic                  pc_ready_c;
  logic                  push_c;
  logic                  pop_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [ADDR_WIDTH-1:0] pc_aligned_c;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_valid;
  logic [ENTRY_W-1:0]    fifo_data;

  assign pc_aligned_c  = pc_i & ~ADDR_WIDTH'(3);
  assign outstanding_c = (state_q != IDLE);
  // New fetch allowed only if buffered plus in-flight words leave a free slot
  assign launch_c = run_q && pc_valid_i && !flush_i &&
                    ((SUM_W'(fifo_count) + SUM_W'(outstanding_c)) < SUM_W'(FIFO_DEPTH));
  assign pop_c    = fifo_valid && instr_ready_i;

  // Holds off requests until the first clock edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_q <= 1'b0;
    else     run_q <= 1'b1;
  end

  // FSM, request address and discard flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
    end
  end

  // Next-state and request/handshake outputs
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    discard_d  = discard_q;
    req_c      = 1'b0;
    addr_c     = '0;
    pc_ready_c = 1'b0;
    push_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch_c) begin
          req_c  = 1'b1;
          addr_c = pc_aligned_c;
          addr_d = pc_aligned_c;
          if (instr_gnt_i) begin
            pc_ready_c = 1'b1;
            state_d    = WAIT;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        req_c  = 1'b1;
        addr_c = addr_q;
        if (instr_gnt_i) begin
          pc_ready_c = 1'b1;
          discard_d  = flush_i;
          state_d    = WAIT;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (flush_i) discard_d = 1'b1;
        if (instr_rvalid_i) begin
          push_c    = !(discard_q || flush_i);
          discard_d = 1'b0;
          if (launch_c && !discard_q) begin
            addr_d  = pc_aligned_c;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .flush_i (flush_i),
    .data_i  ({instr_rdata_i, addr_q}),
    .data_o  (fifo_data),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign instr_req_o   = req_c;
  assign instr_addr_o  = addr_c;
  assign pc_ready_o    = pc_ready_c;
  assign instr_valid_o = fifo_valid;
  assign instr_o       = fifo_data[ENTRY_W-1:ADDR_WIDTH];
  assign instr_pc_o    = fifo_data[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table plus multi-cycle corner sequences.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        pc_valid_i = 1'b0;
  logic        pc_ready_o;
  logic        flush_i = 1'b0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        pv;
    logic        fl;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_prdy;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t tab[19];

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .pc_i           (pc_i),
    .pc_valid_i     (pc_valid_i),
    .pc_ready_o     (pc_ready_o),
    .flush_i        (flush_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .instr_o        (instr_o),
    .instr_pc_o     (instr_pc_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, settle, then let the caller sample
  task automatic cyc(input logic [31:0] pc, input logic pv, input logic fl, input logic gnt,
                     input logic rv, input logic [31:0] rd, input logic rdy);
    @(negedge clk);
    pc_i           = pc;
    pc_valid_i     = pv;
    flush_i        = fl;
    instr_gnt_i    = gnt;
    instr_rvalid_i = rv;
    instr_rdata_i  = rd;
    instr_ready_i  = rdy;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, " req"},   instr_req_o,   1'b0);
    chk ({tag, " addr"},  instr_addr_o,  32'h0);
    chk1({tag, " prdy"},  pc_ready_o,    1'b0);
    chk1({tag, " valid"}, instr_valid_o, 1'b0);
    chk ({tag, " instr"}, instr_o,       32'h0);
    chk ({tag, " ipc"},   instr_pc_o,    32'h0);
  endtask

  // Hold reset with a valid PC present, then release and confirm no request before the next edge
  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    pc_i           = 32'h0001_0074;
    pc_valid_i     = 1'b1;
    flush_i        = 1'b0;
    instr_gnt_i    = 1'b1;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    instr_ready_i  = 1'b0;
    @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("release req", instr_req_o, 1'b0);
    chk1("release prdy", pc_ready_o, 1'b0);
    pc_valid_i  = 1'b0;
    instr_gnt_i = 1'b0;
  endtask

  function automatic vec_t mk(input logic [31:0] pc, input logic pv, input logic fl,
                              input logic gnt, input logic rv, input logic [31:0] rd,
                              input logic rdy, input logic e_req, input logic [31:0] e_addr,
                              input logic e_prdy, input logic e_vld, input logic [31:0] e_instr,
                              input logic [31:0] e_ipc);
    vec_t v;
    v.pc = pc; v.pv = pv; v.fl = fl; v.gnt = gnt; v.rv = rv; v.rdata = rd; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_prdy = e_prdy; v.e_vld = e_vld;
    v.e_instr = e_instr; v.e_ipc = e_ipc;
    return v;
  endfunction

  int pulses;

  initial begin
    // pc, pv, fl, gnt, rv, rdata, rdy | req, addr, prdy, vld, instr, ipc
    tab[0]  = mk(32'h10074,1,0,1,0,32'h0,0,        1,32'h10074,1, 0,32'h0,32'h0);
    tab[1]  = mk(32'h10078,0,0,0,1,32'h00000013,0, 0,32'h0,0,     0,32'h0,32'h0);
    tab[2]  = mk(32'h0,0,0,0,0,32'h0,0,            0,32'h0,0,     1,32'h00000013,32'h10074);
    tab[3]  = mk(32'h0,0,0,0,0,32'h0,1,            0,32'h0,0,     1,32'h00000013,32'h10074);
    tab[4]  = mk(32'h0,0,0,0,0,32'h0,0,            0,32'h0,0,     0,32'h0,32'h0);
    tab[5]  = mk(32'h10078,1,0,1,0,32'h0,0,        1,32'h10078,1, 0,32'h0,32'h0);
    tab[6]  = mk(32'h1007C,1,0,0,1,32'hAAAA0001,0, 0,32'h0,0,     0,32'h0,32'h0);
    tab[7]  = mk(32'h1007C,1,0,1,0,32'h0,0,        1,32'h1007C,1, 1,32'hAAAA0001,32'h10078);
    tab[8]  = mk(32'h10080,1,0,0,1,32'hBBBB0002,0, 0,32'h0,0,     1,32'hAAAA0001,32'h10078);
    tab[9]  = mk(32'h10080,1,0,1,0,32'h0,0,        0,32'h0,0,     1,32'hAAAA0001,32'h10078);
    tab[10] = mk(32'h10080,1,0,1,0,32'h0,1,        0,32'h0,0,     1,32'hAAAA0001,32'h10078);
    tab[11] = mk(32'h10080,1,0,0,0,32'h0,0,        1,32'h10080,0, 1,32'hBBBB0002,32'h1007C);
    tab[12] = mk(32'h10080,1,0,1,0,32'h0,0,        1,32'h10080,1, 1,32'hBBBB0002,32'h1007C);
    tab[13] = mk(32'h10100,0,1,0,0,32'h0,0,        0,32'h0,0,     1,32'hBBBB0002,32'h1007C);
    tab[14] = mk(32'h10100,1,0,0,1,32'hDEAD0000,0, 0,32'h0,0,     0,32'h0,32'h0);
    tab[15] = mk(32'h10100,1,0,1,0,32'h0,0,        1,32'h10100,1, 0,32'h0,32'h0);
    tab[16] = mk(32'h0,0,0,0,1,32'h00500093,0,     0,32'h0,0,     0,32'h0,32'h0);
    tab[17] = mk(32'h0,0,0,0,0,32'h0,1,            0,32'h0,0,     1,32'h00500093,32'h10100);
    tab[18] = mk(32'h0,0,0,0,0,32'h0,0,            0,32'h0,0,     0,32'h0,32'h0);

    do_reset();

    // Basic fetch, buffering backpressure, flush in WAIT
    for (int i = 0; i < 19; i++) begin
      cyc(tab[i].pc, tab[i].pv, tab[i].fl, tab[i].gnt, tab[i].rv, tab[i].rdata, tab[i].rdy);
      chk1($sformatf("v%0d req", i), instr_req_o, tab[i].e_req);
      if (tab[i].e_req) chk($sformatf("v%0d addr", i), instr_addr_o, tab[i].e_addr);
      chk1($sformatf("v%0d prdy", i), pc_ready_o, tab[i].e_prdy);
      chk1($sformatf("v%0d valid", i), instr_valid_o, tab[i].e_vld);
      if (tab[i].e_vld) begin
        chk($sformatf("v%0d instr", i), instr_o, tab[i].e_instr);
        chk($sformatf("v%0d ipc", i), instr_pc_o, tab[i].e_ipc);
      end
    end

    do_reset();

    // Delayed grant: request and aligned address held, exactly one pc_ready pulse
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(32'h20003, 1'b1, 1'b0, (i == 3), 1'b0, 32'h0, 1'b0);
      chk1($sformatf("gnt_dly%0d req", i), instr_req_o, 1'b1);
      chk($sformatf("gnt_dly%0d addr", i), instr_addr_o, 32'h20000);
      chk1($sformatf("gnt_dly%0d prdy", i), pc_ready_o, (i == 3));
      if (pc_ready_o) pulses++;
    end
    cyc(32'h20004, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0);
    if (pc_ready_o) pulses++;
    chk("gnt_dly pulses", 32'(pulses), 32'd1);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk1("gnt_dly valid", instr_valid_o, 1'b1);
    chk("gnt_dly instr", instr_o, 32'h12345678);
    chk("gnt_dly ipc", instr_pc_o, 32'h20000);

    // Flush in REQ without grant: back to IDLE, no pc_ready
    cyc(32'h30000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk1("flreq req", instr_req_o, 1'b1);
    cyc(32'h30000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk1("flreq prdy", pc_ready_o, 1'b0);
    cyc(32'h30000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk1("flreq idle req", instr_req_o, 1'b0);

    // Flush with grant in REQ: granted, but its response is dropped
    cyc(32'h30004, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk1("flgnt req0", instr_req_o, 1'b1);
    cyc(32'h30004, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk1("flgnt prdy", pc_ready_o, 1'b1);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000BAD1, 1'b0);
    chk1("flgnt rv req", instr_req_o, 1'b0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk1("flgnt dropped", instr_valid_o, 1'b0);

    // Flush and rvalid in the same WAIT cycle, then confirm fetch still works
    cyc(32'h30008, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk1("flrv prdy", pc_ready_o, 1'b1);
    cyc(32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000BAD2, 1'b0);
    cyc(32'h3000C, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk1("flrv dropped", instr_valid_o, 1'b0);
    chk1("flrv next req", instr_req_o, 1'b1);
    chk1("flrv next prdy", pc_ready_o, 1'b1);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000600D, 1'b0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk1("flrv good valid", instr_valid_o, 1'b1);
    chk("flrv good instr", instr_o, 32'h0000600D);
    chk("flrv good ipc", instr_pc_o, 32'h3000C);

    // Reset asserted while in WAIT with a buffered word; late rvalid ignored
    cyc(32'h40000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000077, 1'b0);
    cyc(32'h40004, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk1("rstw pre valid", instr_valid_o, 1'b1);
    chk1("rstw pre prdy", pc_ready_o, 1'b1);
    @(negedge clk);
    rst            = 1'b1;
    pc_valid_i     = 1'b0;
    instr_gnt_i    = 1'b0;
    #1;
    chk_all_zero("rstw");
    @(negedge clk);
    rst            = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'h00000099;
    #1;
    chk1("rstw late req", instr_req_o, 1'b0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk1("rstw late valid", instr_valid_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
